spi_fread_arb: RTL

Round-robin arbiter that shares one spi_dev_fread request/stream interface (STREAM mode) between N_REQ independent requesters, e.g. a RAM loader, a UART dumper and a config fetcher.
Grants one requester at a time and latches its request, then issues the request downstream.
Routes the response byte stream back to the owner and holds ownership until all len+1 bytes have arrived.
Sits between user logic and spi_dev_fread.

---
 rtl/spi_fread_pkg.sv | 15 +
 rtl/spi_fread_rr_pick.sv | 29 ++
 rtl/spi_fread_arb.sv | 132 +++++++++++++
 3 files changed

// File: rtl/spi_fread_pkg.sv
// Shared types and widths for the spi_dev_fread requester arbiter.
// Pure declarations, no logic.
package spi_fread_pkg;

  localparam int FID_W = 32;
  localparam int OFS_W = 32;
  localparam int LEN_W = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    STREAM = 2'd2
  } state_t;

endpackage

// File: rtl/spi_fread_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
// Zero latency; no flow control of its own.
module spi_fread_rr_pick #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] idx,
  output logic          any
);

  int c;

  always_comb begin
    idx = '0;
    any = 1'b0;
    c   = 0;
    // Scan from the farthest offset down so the nearest one to ptr wins last.
    for (int k = N - 1; k >= 0; k--) begin
      c = (int'(ptr) + k) % N;
      if (req[c]) begin
        idx = IW'(c);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_fread_arb.sv
// Round-robin share of one spi_dev_fread request/stream port among N_REQ requesters.
// Grant pulse and response bytes are registered (1 cycle); req_valid holds until req_ready.
module spi_fread_arb
  import spi_fread_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int LEN_W = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [FID_W*N_REQ-1:0]     rq_file_id,
  input  logic [OFS_W*N_REQ-1:0]     rq_offset,
  input  logic [LEN_W*N_REQ-1:0]     rq_len,
  input  logic [N_REQ-1:0]           rq_valid,
  output logic [N_REQ-1:0]           rq_ready,
  output logic [7:0]                 rsp_data,
  output logic [N_REQ-1:0]           rsp_valid,
  output logic                       rsp_last,
  output logic [FID_W-1:0]           req_file_id,
  output logic [OFS_W-1:0]           req_offset,
  output logic [LEN_W-1:0]           req_len,
  output logic                       req_valid,
  input  logic                       req_ready,
  input  logic [7:0]                 resp_data,
  input  logic                       resp_valid,
  output logic                       busy,
  output logic [$clog2(N_REQ)-1:0]   owner,
  output logic                       err_stb
);

  localparam int IW = $clog2(N_REQ);

  state_t           state;
  logic [IW-1:0]    rr_ptr;
  logic [IW-1:0]    pick_idx;
  logic             pick_any;
  logic [N_REQ-1:0] pick_oh;
  logic [N_REQ-1:0] own_oh;
  logic [FID_W-1:0] fid_q;
  logic [OFS_W-1:0] ofs_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W:0]   cnt;
  logic             last_byte;

  spi_fread_rr_pick #(
    .N (N_REQ)
  ) u_pick (
    .req (rq_valid),
    .ptr (rr_ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign pick_oh     = N_REQ'(1) << pick_idx;
  assign own_oh      = N_REQ'(1) << owner;
  // One bit wider than len so len=all-ones still terminates without wrap.
  assign last_byte   = (cnt == {1'b0, len_q});

  assign req_file_id = fid_q;
  assign req_offset  = ofs_q;
  assign req_len     = len_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      fid_q     <= '0;
      ofs_q     <= '0;
      len_q     <= '0;
      cnt       <= '0;
      rq_ready  <= '0;
      rsp_data  <= '0;
      rsp_valid <= '0;
      rsp_last  <= 1'b0;
      req_valid <= 1'b0;
      busy      <= 1'b0;
      err_stb   <= 1'b0;
    end else begin
      rq_ready  <= '0;
      rsp_valid <= '0;
      rsp_last  <= 1'b0;
      err_stb   <= 1'b0;

      case (state)
        IDLE: begin
          if (resp_valid) err_stb <= 1'b1;
          if (pick_any) begin
            fid_q     <= rq_file_id[pick_idx*FID_W +: FID_W];
            ofs_q     <= rq_offset[pick_idx*OFS_W +: OFS_W];
            len_q     <= rq_len[pick_idx*LEN_W +: LEN_W];
            owner     <= pick_idx;
            rq_ready  <= pick_oh;
            rr_ptr    <= (pick_idx == IW'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
            req_valid <= 1'b1;
            busy      <= 1'b1;
            state     <= ISSUE;
          end
        end

        ISSUE: begin
          if (resp_valid) err_stb <= 1'b1;
          if (req_ready) begin
            req_valid <= 1'b0;
            cnt       <= '0;
            state     <= STREAM;
          end
        end

        STREAM: begin
          if (resp_valid) begin
            rsp_data  <= resp_data;
            rsp_valid <= own_oh;
            cnt       <= cnt + 1'b1;
            if (last_byte) begin
              rsp_last <= 1'b1;
              busy     <= 1'b0;
              state    <= IDLE;
            end
          end
        end

        default: begin
          req_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
